// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register specifiers: recycles committed previous
// mappings and hands free registers to rename through a val/rdy allocation port.
module phys_reg_free_list #(
   parameter int unsigned p_num_phys_regs  = 64,
   parameter int unsigned p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc_val,
   output logic                        alloc_rdy,
   output logic [p_phys_addr_bits-1:0] alloc_preg,
   input  logic                        commit_val,
   input  logic                        commit_wen,
   input  logic [p_phys_addr_bits-1:0] commit_ppreg,
   output logic [$clog2(p_num_phys_regs-32+1)-1:0] free_count,
   output logic                        overflow
);

   localparam int unsigned p_depth    = p_num_phys_regs - 32;
   localparam int unsigned p_cnt_bits = $clog2(p_depth + 1);
   localparam int unsigned p_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;

   localparam logic [p_cnt_bits-1:0] CntFull = p_cnt_bits'(p_depth);
   localparam logic [p_ptr_bits-1:0] PtrLast = p_ptr_bits'(p_depth - 1);

   logic [p_phys_addr_bits-1:0] mem_q [p_depth];
   logic [p_ptr_bits-1:0]       head_q, head_d;
   logic [p_ptr_bits-1:0]       tail_q, tail_d;
   logic [p_cnt_bits-1:0]       count_q, count_d;
   logic                        overflow_q, overflow_d;

   logic pop_fire;
   logic push_req;
   logic push_fire;

   // Pointers wrap explicitly so the depth need not be a power of two.
   function automatic logic [p_ptr_bits-1:0] ptr_inc(input logic [p_ptr_bits-1:0] ptr);
      return (ptr == PtrLast) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      pop_fire  = alloc_val && (count_q != '0);
      push_req  = commit_val && commit_wen;
      // A pop in the same cycle frees a slot, so a push at full still fits.
      push_fire = push_req && ((count_q != CntFull) || pop_fire);
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (pop_fire) begin
         head_d = ptr_inc(head_q);
      end
      if (push_fire) begin
         tail_d = ptr_inc(tail_q);
      end
      unique case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (push_req && !push_fire) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= CntFull;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Registers 0..31 hold architectural state at reset; the list starts with 32 upward.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(p_depth); i++) begin
            mem_q[i] <= p_phys_addr_bits'(32 + i);
         end
      end else if (push_fire) begin
         mem_q[tail_q] <= commit_ppreg;
      end
   end

   assign alloc_rdy  = (count_q != '0);
   assign alloc_preg = mem_q[head_q];
   assign free_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed test-plan scenarios then random traffic,
// compared against a queue-based model of the free list.
module tb_phys_reg_free_list;

   localparam int unsigned NumRegs = 36;
   localparam int unsigned Depth   = NumRegs - 32;
   localparam int unsigned AW      = $clog2(NumRegs);
   localparam int unsigned CW      = $clog2(Depth + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_val;
   logic          alloc_rdy;
   logic [AW-1:0] alloc_preg;
   logic          commit_val;
   logic          commit_wen;
   logic [AW-1:0] commit_ppreg;
   logic [CW-1:0] free_count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   int m_q[$];
   bit m_ovf;

   always #5 clk = ~clk;

   phys_reg_free_list #(
      .p_num_phys_regs(NumRegs)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_val   (alloc_val),
      .alloc_rdy   (alloc_rdy),
      .alloc_preg  (alloc_preg),
      .commit_val  (commit_val),
      .commit_wen  (commit_wen),
      .commit_ppreg(commit_ppreg),
      .free_count  (free_count),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_q = {};
      for (int i = 0; i < int'(Depth); i++) m_q.push_back(32 + i);
      m_ovf = 1'b0;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_rdy"}, int'(alloc_rdy), (m_q.size() != 0) ? 1 : 0);
      check({tag, "_cnt"}, int'(free_count), m_q.size());
      check({tag, "_ovf"}, int'(overflow), int'(m_ovf));
      if (m_q.size() != 0) check({tag, "_preg"}, int'(alloc_preg), m_q[0]);
   endtask

   // Called at a negedge: drive inputs, compare, update the model for the coming edge.
   task automatic cycle(input string tag, input bit av, input bit cv, input bit cw,
                        input int pp);
      bit pop;
      alloc_val    = av;
      commit_val   = cv;
      commit_wen   = cw;
      commit_ppreg = AW'(pp);
      #1;
      check_outputs(tag);
      pop = av && (m_q.size() != 0);
      if (pop) void'(m_q.pop_front());
      if (cv && cw) begin
         if (m_q.size() < int'(Depth)) m_q.push_back(pp);
         else m_ovf = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input bit av, input bit cv, input int pp);
      rst          = 1'b1;
      alloc_val    = av;
      commit_val   = cv;
      commit_wen   = cv;
      commit_ppreg = AW'(pp);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst          = 1'b1;
      alloc_val    = 1'b0;
      commit_val   = 1'b0;
      commit_wen   = 1'b0;
      commit_ppreg = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // 1: reset state and drain
      check("rst_rdy", int'(alloc_rdy), 1);
      check("rst_preg", int'(alloc_preg), 32);
      check("rst_cnt", int'(free_count), 4);
      check("rst_ovf", int'(overflow), 0);
      for (int i = 0; i < 5; i++) cycle("drain", 1, 0, 0, 0);
      check("drain_rdy", int'(alloc_rdy), 0);
      check("drain_cnt", int'(free_count), 0);

      // 2: free when empty, no bypass
      cycle("empty_push", 1, 1, 1, 7);
      check("nobyp_rdy", int'(alloc_rdy), 1);
      check("nobyp_preg", int'(alloc_preg), 7);
      cycle("empty_grant", 1, 0, 0, 0);
      check("empty_after_cnt", int'(free_count), 0);

      // 3: wrap-around order
      cycle("wrap_p3", 0, 1, 1, 3);
      cycle("wrap_p9", 0, 1, 1, 9);
      cycle("wrap_p12", 0, 1, 1, 12);
      cycle("wrap_p20", 0, 1, 1, 20);
      check("wrap_first", int'(alloc_preg), 3);
      for (int i = 0; i < 4; i++) cycle("wrap_pop", 1, 0, 0, 0);
      check("wrap_cnt", int'(free_count), 0);

      // 4: simultaneous pop and push at full
      do_reset(0, 0, 0);
      check("full_sim_preg", int'(alloc_preg), 32);
      cycle("full_sim", 1, 1, 1, 5);
      check("full_sim_cnt", int'(free_count), 4);
      for (int i = 0; i < 3; i++) cycle("full_pop", 1, 0, 0, 0);
      check("full_next5", int'(alloc_preg), 5);
      check("full_ovf", int'(overflow), 0);

      // 5: overflow and wen masking
      do_reset(0, 0, 0);
      cycle("ovf_push", 0, 1, 1, 6);
      check("ovf_set", int'(overflow), 1);
      check("ovf_cnt", int'(free_count), 4);
      cycle("wen0", 0, 1, 0, 8);
      check("wen0_cnt", int'(free_count), 4);
      check("wen0_preg", int'(alloc_preg), 32);
      do_reset(0, 0, 0);
      check("ovf_clr", int'(overflow), 0);

      // 6: reset mid-stream discards the in-flight push
      cycle("mid_pop", 1, 0, 0, 0);
      cycle("mid_pop", 1, 0, 0, 0);
      do_reset(1, 1, 11);
      check("mid_preg", int'(alloc_preg), 32);
      check("mid_cnt", int'(free_count), 4);
      for (int i = 0; i < 4; i++) cycle("mid_drain", 1, 0, 0, 0);

      // Random traffic with phases biased towards filling or draining
      for (int i = 0; i < 600; i++) begin
         bit fill;
         fill = ((i / 40) % 2) == 0;
         if ($urandom_range(0, 99) == 0) begin
            do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, NumRegs - 1)));
         end else begin
            cycle("rand",
                  fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 4) != 0,
                  int'($urandom_range(0, NumRegs - 1)));
         end
      end
      #1;
      check_outputs("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
